// File: rtl/fixed_vector_mult_folded_if.sv
`default_nettype none
// ============================================================================
// Module      : fixed_vector_mult_folded_if
// Description : Join-handshake bus for the folded element-wise vector multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface fixed_vector_mult_folded_if #(
   parameter int IN_WIDTH     = 16,
   parameter int WEIGHT_WIDTH = 16,
   parameter int OUT_WIDTH    = IN_WIDTH + WEIGHT_WIDTH,
   parameter int IN_SIZE      = 8
);
   logic [IN_SIZE-1:0][IN_WIDTH-1:0]     data_in;
   logic                                 data_in_valid;
   logic                                 data_in_ready;
   logic [IN_SIZE-1:0][WEIGHT_WIDTH-1:0] weight;
   logic                                 weight_valid;
   logic                                 weight_ready;
   logic [IN_SIZE-1:0][OUT_WIDTH-1:0]    data_out;
   logic                                 data_out_valid;
   logic                                 data_out_ready;

   modport master (
      output data_in, data_in_valid, weight, weight_valid, data_out_ready,
      input  data_in_ready, weight_ready, data_out, data_out_valid
   );

   modport slave (
      input  data_in, data_in_valid, weight, weight_valid, data_out_ready,
      output data_in_ready, weight_ready, data_out, data_out_valid
   );
endinterface
`default_nettype wire

// File: rtl/fixed_vector_mult_folded.sv
`default_nettype none
// ============================================================================
// Module      : fixed_vector_mult_folded
// Description : Element-wise signed vector multiply folded over PARALLELISM
//               lanes; optional output saturation via FIXED_VECTOR_MULT_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_vector_mult_folded #(
   parameter int IN_WIDTH       = 16,
   parameter int WEIGHT_WIDTH   = 16,
   parameter int OUT_WIDTH      = IN_WIDTH + WEIGHT_WIDTH,
   parameter int OUT_FRAC_SHIFT = 0,
   parameter int IN_SIZE        = 8,
   parameter int PARALLELISM    = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   fixed_vector_mult_folded_if.slave    bus
);

   localparam int C_NUM_BEATS = IN_SIZE / PARALLELISM;
   localparam int C_BW        = (C_NUM_BEATS > 1) ? $clog2(C_NUM_BEATS) : 1;
   localparam int C_PW        = IN_WIDTH + WEIGHT_WIDTH;
   localparam int C_RW        = C_PW + 1;
   localparam int C_RND_POS   = (OUT_FRAC_SHIFT > 0) ? OUT_FRAC_SHIFT - 1 : 0;
   localparam logic signed [C_RW-1:0] C_RND =
      (OUT_FRAC_SHIFT > 0) ? (C_RW'(1) << C_RND_POS) : '0;
   localparam logic [C_BW-1:0] C_LAST_BEAT = C_BW'(C_NUM_BEATS - 1);

   if (IN_SIZE % PARALLELISM != 0) begin : g_cfg_check
      $error("fixed_vector_mult_folded: IN_SIZE must be a multiple of PARALLELISM");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t                                                     r_state;
   state_t                                                     w_state_nxt;
   logic [C_NUM_BEATS-1:0][PARALLELISM-1:0][IN_WIDTH-1:0]      r_a;
   logic [C_NUM_BEATS-1:0][PARALLELISM-1:0][WEIGHT_WIDTH-1:0]  r_w;
   logic [C_NUM_BEATS-1:0][PARALLELISM-1:0][OUT_WIDTH-1:0]     r_out;
   logic [C_BW-1:0]                                            r_beat;
   logic                                                       r_out_valid;
   logic                                                       w_accept;
   logic                                                       w_fire;
   logic                                                       w_last;
   logic [PARALLELISM-1:0][OUT_WIDTH-1:0]                      w_lane_res;

   // Round half up: sum is one bit wider than the product so it cannot overflow.
   function automatic logic signed [C_RW-1:0] f_round(input logic signed [C_PW-1:0] p);
      f_round = (C_RW'(p) + C_RND) >>> OUT_FRAC_SHIFT;
   endfunction

   assign w_accept = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.data_out_ready);
   assign w_fire   = w_accept && bus.data_in_valid && bus.weight_valid;
   assign w_last   = (r_beat == C_LAST_BEAT);

   assign bus.data_in_ready  = w_accept && bus.weight_valid;
   assign bus.weight_ready   = w_accept && bus.data_in_valid;
   assign bus.data_out       = r_out;
   assign bus.data_out_valid = r_out_valid;

   for (genvar j = 0; j < PARALLELISM; j++) begin : g_lane
      logic signed [C_PW-1:0] w_prod;

      assign w_prod = C_PW'($signed(r_a[r_beat][j])) * C_PW'($signed(r_w[r_beat][j]));

`ifdef FIXED_VECTOR_MULT_SAT_EN
      if (OUT_WIDTH < C_RW) begin : g_sat
         logic signed [C_RW-1:0] w_rnd;
         logic                   w_fits;

         assign w_rnd  = f_round(w_prod);
         // In range exactly when every bit above the output sign bit matches it.
         assign w_fits = (&w_rnd[C_RW-1:OUT_WIDTH-1]) | ~(|w_rnd[C_RW-1:OUT_WIDTH-1]);
         assign w_lane_res[j] = w_fits ? w_rnd[OUT_WIDTH-1:0]
                                       : {w_rnd[C_RW-1], {(OUT_WIDTH-1){~w_rnd[C_RW-1]}}};
      end else begin : g_wide
         assign w_lane_res[j] = OUT_WIDTH'(f_round(w_prod));
      end
`else
      assign w_lane_res[j] = OUT_WIDTH'(f_round(w_prod));
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_fire) w_state_nxt = S_COMPUTE;
         end
         S_COMPUTE: begin
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (w_fire)                   w_state_nxt = S_COMPUTE;
            else if (bus.data_out_ready)  w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_w         <= '0;
         r_out       <= '0;
         r_beat      <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= (w_state_nxt == S_DONE);
         if (w_fire) begin
            r_a    <= bus.data_in;
            r_w    <= bus.weight;
            r_beat <= '0;
         end else if (r_state == S_COMPUTE) begin
            r_out[r_beat] <= w_lane_res;
            r_beat        <= w_last ? '0 : r_beat + C_BW'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fixed_vector_mult_folded.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixed_vector_mult_folded
// Description : Directed bench for three multiplier configurations (plain,
//               rounding/narrowing, wide folded stream with golden model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_vector_mult_folded;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   fixed_vector_mult_folded_if #(.IN_WIDTH(8),  .WEIGHT_WIDTH(8),  .OUT_WIDTH(16), .IN_SIZE(4)) ifa();
   fixed_vector_mult_folded_if #(.IN_WIDTH(8),  .WEIGHT_WIDTH(8),  .OUT_WIDTH(8),  .IN_SIZE(4)) ifb();
   fixed_vector_mult_folded_if #(.IN_WIDTH(16), .WEIGHT_WIDTH(16), .OUT_WIDTH(32), .IN_SIZE(8)) ifc();

   fixed_vector_mult_folded #(
      .IN_WIDTH(8), .WEIGHT_WIDTH(8), .OUT_WIDTH(16), .OUT_FRAC_SHIFT(0), .IN_SIZE(4), .PARALLELISM(2)
   ) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));

   fixed_vector_mult_folded #(
      .IN_WIDTH(8), .WEIGHT_WIDTH(8), .OUT_WIDTH(8), .OUT_FRAC_SHIFT(4), .IN_SIZE(4), .PARALLELISM(4)
   ) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   fixed_vector_mult_folded #(
      .IN_WIDTH(16), .WEIGHT_WIDTH(16), .OUT_WIDTH(32), .OUT_FRAC_SHIFT(0), .IN_SIZE(8), .PARALLELISM(4)
   ) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

`ifdef FIXED_VECTOR_MULT_SAT_EN
   localparam logic [31:0] C_B1_EXP = 32'h8002_FF7F;
   localparam logic [31:0] C_B2_EXP = 32'h007F_0001;
`else
   localparam logic [31:0] C_B1_EXP = 32'h0802_FF00;
   localparam logic [31:0] C_B2_EXP = 32'h00F0_0001;
`endif
   localparam int C_NV = 60;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic a_run(input string tag, input logic [31:0] d, input logic [31:0] w,
                        input logic [63:0] exp);
      @(negedge clk);
      ifa.data_in = d;  ifa.weight = w;
      ifa.data_in_valid = 1'b1; ifa.weight_valid = 1'b1; ifa.data_out_ready = 1'b1;
      #1 check({tag, "_rdy"}, 64'(ifa.data_in_ready), 64'd1);
      @(negedge clk);
      ifa.data_in_valid = 1'b0; ifa.weight_valid = 1'b0;
      check({tag, "_v0"}, 64'(ifa.data_out_valid), 64'd0);
      @(negedge clk);
      check({tag, "_v1"}, 64'(ifa.data_out_valid), 64'd0);
      @(negedge clk);
      check({tag, "_v2"}, 64'(ifa.data_out_valid), 64'd1);
      check({tag, "_data"}, 64'(ifa.data_out), exp);
   endtask

   task automatic b_run(input string tag, input logic [31:0] d, input logic [31:0] w,
                        input logic [31:0] exp);
      @(negedge clk);
      ifb.data_in = d;  ifb.weight = w;
      ifb.data_in_valid = 1'b1; ifb.weight_valid = 1'b1; ifb.data_out_ready = 1'b1;
      @(negedge clk);
      ifb.data_in_valid = 1'b0; ifb.weight_valid = 1'b0;
      check({tag, "_v0"}, 64'(ifb.data_out_valid), 64'd0);
      @(negedge clk);
      check({tag, "_v1"}, 64'(ifb.data_out_valid), 64'd1);
      check({tag, "_data"}, 64'(ifb.data_out), 64'(exp));
   endtask

   function automatic logic [255:0] c_model(input logic [127:0] d, input logic [127:0] w);
      logic signed [15:0] a;
      logic signed [15:0] b;
      logic signed [31:0] p;
      c_model = '0;
      for (int i = 0; i < 8; i++) begin
         a = d[16*i +: 16];
         b = w[16*i +: 16];
         p = a * b;
         c_model[32*i +: 32] = p;
      end
   endfunction

   function automatic logic [15:0] c_elem();
      int r;
      r = $urandom_range(0, 3);
      if (r == 0)      c_elem = 16'h8000;
      else if (r == 1) c_elem = 16'h7FFF;
      else             c_elem = 16'($urandom);
   endfunction

   initial begin
      logic [255:0]  q[$];
      logic [255:0]  exp_c;
      logic [127:0]  cd;
      logic [127:0]  cw;
      bit            have;
      int            sent;
      int            got;
      int            cnt;

      n_vec = 0; n_err = 0;
      rst_n = 1'b0;
      ifa.data_in = '0; ifa.weight = '0; ifa.data_in_valid = 1'b0; ifa.weight_valid = 1'b0; ifa.data_out_ready = 1'b1;
      ifb.data_in = '0; ifb.weight = '0; ifb.data_in_valid = 1'b0; ifb.weight_valid = 1'b0; ifb.data_out_ready = 1'b1;
      ifc.data_in = '0; ifc.weight = '0; ifc.data_in_valid = 1'b0; ifc.weight_valid = 1'b0; ifc.data_out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_a_valid", 64'(ifa.data_out_valid), 64'd0);
      check("rst_a_data",  64'(ifa.data_out), 64'd0);
      check("rst_b_valid", 64'(ifb.data_out_valid), 64'd0);
      check("rst_b_data",  64'(ifb.data_out), 64'd0);
      check("rst_c_valid", 64'(ifc.data_out_valid), 64'd0);
      check("rst_c_zero",  64'(ifc.data_out == '0), 64'd1);
      rst_n = 1'b1;

      // Basic multiply: {1,-2,3,127} * {5,7,-4,-128}
      a_run("t1", 32'h7F03_FE01, 32'h80FC_0705, 64'hC080_FFF4_FFF2_0005);

      // Join handshake: activation alone never transfers
      @(negedge clk);
      ifa.data_in = 32'hFBFF_0302; ifa.weight = 32'hFD0A_FA04;
      ifa.data_in_valid = 1'b1; ifa.weight_valid = 1'b0; ifa.data_out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("t3_din_rdy", 64'(ifa.data_in_ready), 64'd0);
         check("t3_w_rdy",   64'(ifa.weight_ready), 64'd1);
         check("t3_valid",   64'(ifa.data_out_valid), 64'd0);
         @(negedge clk);
      end
      ifa.weight_valid = 1'b1;
      #1 check("t3_fire_rdy", 64'(ifa.data_in_ready), 64'd1);
      @(negedge clk);
      ifa.data_in_valid = 1'b0; ifa.weight_valid = 1'b0;
      check("t3_v0", 64'(ifa.data_out_valid), 64'd0);
      @(negedge clk);
      check("t3_v1", 64'(ifa.data_out_valid), 64'd0);
      @(negedge clk);
      check("t3_v2",   64'(ifa.data_out_valid), 64'd1);
      check("t3_data", 64'(ifa.data_out), 64'h000F_FFF6_FFEE_0008);

      // Backpressure with the next vector pending
      ifa.data_in = 32'h0064_FFFF; ifa.weight = 32'h3702_7FFF;
      ifa.data_in_valid = 1'b1; ifa.weight_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("t4_hold_valid", 64'(ifa.data_out_valid), 64'd1);
         check("t4_hold_data",  64'(ifa.data_out), 64'h000F_FFF6_FFEE_0008);
         check("t4_din_rdy",    64'(ifa.data_in_ready), 64'd0);
         check("t4_w_rdy",      64'(ifa.weight_ready), 64'd0);
      end
      ifa.data_out_ready = 1'b1;
      #1 check("t4_accept_rdy", 64'(ifa.data_in_ready & ifa.weight_ready), 64'd1);
      @(negedge clk);
      ifa.data_in_valid = 1'b0; ifa.weight_valid = 1'b0;
      check("t4_v0", 64'(ifa.data_out_valid), 64'd0);
      @(negedge clk);
      check("t4_v1", 64'(ifa.data_out_valid), 64'd0);
      @(negedge clk);
      check("t4_v2",   64'(ifa.data_out_valid), 64'd1);
      check("t4_data", 64'(ifa.data_out), 64'h0000_00C8_FF81_0001);

      // Mid-operation asynchronous reset during beat 1
      @(negedge clk);
      ifa.data_in = 32'hF907_F60A; ifa.weight = 32'h0303_0303;
      ifa.data_in_valid = 1'b1; ifa.weight_valid = 1'b1;
      @(negedge clk);
      ifa.data_in_valid = 1'b0; ifa.weight_valid = 1'b0;
      @(posedge clk);
      #2 check("t6_pre_nonzero", 64'(ifa.data_out != '0), 64'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 64'(ifa.data_out_valid), 64'd0);
      check("t6_rst_data",  64'(ifa.data_out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      a_run("t6b", 32'h0100_8080, 32'h0180_7F80, 64'h0001_0000_C080_4000);

      // Rounding and narrowing, single-beat configuration
      b_run("t2a", 32'h8018_FD40, 32'h7F01_0540, C_B1_EXP);
      b_run("t2b", 32'hFF7F_FF01, 32'h017F_0808, C_B2_EXP);

      // Folded stream with random valid/ready against the golden model
      have = 1'b0; sent = 0; got = 0; cd = '0; cw = '0;
      for (int cyc = 0; cyc < 4000 && got < C_NV; cyc++) begin
         @(negedge clk);
         if (!have && sent < C_NV) begin
            for (int i = 0; i < 8; i++) begin
               cd[16*i +: 16] = c_elem();
               cw[16*i +: 16] = c_elem();
            end
            have = 1'b1;
         end
         ifc.data_in = cd; ifc.weight = cw;
         ifc.data_in_valid  = have && ($urandom_range(0, 3) != 0);
         ifc.weight_valid   = have && ($urandom_range(0, 3) != 0);
         ifc.data_out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (ifc.data_out_valid && ifc.data_out_ready) begin
            if (q.size() == 0) begin
               check("c_spurious_out", 64'd1, 64'd0);
            end else begin
               exp_c = q.pop_front();
               for (int i = 0; i < 8; i++)
                  check($sformatf("c_vec%0d_e%0d", got, i), 64'(ifc.data_out[i]), 64'(exp_c[32*i +: 32]));
               got++;
            end
         end
         if (ifc.data_in_valid && ifc.data_in_ready) begin
            q.push_back(c_model(cd, cw));
            have = 1'b0;
            sent++;
         end
      end
      check("c_stream_done", 64'(got), 64'(C_NV));

      // Full-flow throughput: one result per NUM_BEATS+1 cycles
      @(negedge clk);
      ifc.data_in_valid = 1'b0; ifc.weight_valid = 1'b0; ifc.data_out_ready = 1'b1;
      repeat (4) @(negedge clk);
      ifc.data_in_valid = 1'b1; ifc.weight_valid = 1'b1;
      cnt = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (ifc.data_out_valid) cnt++;
      end
      check("c_throughput", 64'(cnt), 64'd10);
      ifc.data_in_valid = 1'b0; ifc.weight_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fixed_vector_mult_folded.md
Name: fixed_vector_mult_folded

Overview:
Element-wise signed vector multiplier, data_out[i] = data_in[i] * weight[i], with a configurable number of hardware multiplier lanes. An IN_SIZE vector is folded over IN_SIZE/PARALLELISM compute beats. Each product is rounded, shifted and optionally saturated to OUT_WIDTH. It sits in linear-layer datapaths ahead of adder trees and accumulators, and trades multiplier area for throughput.

Parameters:
IN_WIDTH, 16, signed activation element width
WEIGHT_WIDTH, 16, signed weight element width
OUT_WIDTH, IN_WIDTH+WEIGHT_WIDTH, signed output element width
OUT_FRAC_SHIFT, 0, arithmetic right shift applied to each product; 0 means no shift and no rounding
IN_SIZE, 8, number of vector elements
PARALLELISM, 2, multipliers instantiated; IN_SIZE % PARALLELISM == 0 is required, otherwise elaboration fails ($error)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
data_in  input  IN_WIDTH x IN_SIZE  activation vector
data_in_valid  input  1  activation valid
data_in_ready  output  1  activation ready
weight  input  WEIGHT_WIDTH x IN_SIZE  weight vector
weight_valid  input  1  weight valid
weight_ready  output  1  weight ready
data_out  output  OUT_WIDTH x IN_SIZE  result vector
data_out_valid  output  1  result valid
data_out_ready  input  1  downstream ready

Behaviour:
- Reset: one clock (clk). Asynchronous, active-low reset (rst_n). On reset: state=IDLE, beat counter=0, data_out_valid=0, every data_out element=0, internal operand registers=0. Reset may assert in any state; any in-flight vector is discarded.
- NUM_BEATS = IN_SIZE/PARALLELISM.
- States:
  - IDLE: waiting for an input vector.
  - COMPUTE: beat counter b runs 0..NUM_BEATS-1.
  - DONE: result held on data_out.
- accept_slot = (state==IDLE) || (state==DONE && data_out_ready).
- Join handshake:
  - data_in_ready = accept_slot && weight_valid; weight_ready = accept_slot && data_in_valid.
  - A transfer fires only when both valids are high and accept_slot is high.
  - Neither operand is consumed alone.
- On transfer: latch both full vectors, b<=0, state<=COMPUTE. If in DONE, data_out_valid drops the same edge (output consumed).
- COMPUTE, each cycle: lanes j=0..PARALLELISM-1 process element e=b*PARALLELISM+j and write result register e. b increments. When b==NUM_BEATS-1, state<=DONE and data_out_valid<=1 on that edge.
- DONE, no transfer:
  - data_out_ready=1 → data_out_valid<=0, state<=IDLE.
  - data_out_ready=0 → hold; data_out and data_out_valid stay stable.
- Latency: transfer at edge T gives data_out_valid high after edge T+NUM_BEATS. Back-to-back throughput is one vector per NUM_BEATS+1 cycles (the DONE-state accept overlaps output and input).
- Inputs are ignored outside a transfer; the upstream may change them freely while ready=0.
- Arithmetic, per element:
  - p = signed(a)*signed(w), full width IN_WIDTH+WEIGHT_WIDTH.
  - If OUT_FRAC_SHIFT>0: r = (p + 2^(OUT_FRAC_SHIFT-1)) >>> OUT_FRAC_SHIFT (round half up, toward +inf). Otherwise r = p.
  - The rounding add is computed one bit wider, so it never overflows.
- Result narrowing to OUT_WIDTH is set by the optional feature.
- Result registers not yet written in the current COMPUTE keep their previous values. They are not observable, because data_out_valid=0.

Optional Feature:
FIXED_VECTOR_MULT_SAT_EN
- Defined: r is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] before truncation.
- Undefined: r is truncated to its low OUT_WIDTH bits (two's-complement wrap).
- With default widths and OUT_FRAC_SHIFT=0, both behaviours are identical.

Test Plan:
1. Reset and basic multiply. IN_WIDTH=WEIGHT_WIDTH=8, OUT_WIDTH=16, shift 0, IN_SIZE=4, PARALLELISM=2. Hold rst_n=0 then release; data_in={1,-2,3,127}, weight={5,7,-4,-128}, data_out_ready=1 → data_out={5,-14,-12,-16256}. data_out_valid rises exactly 2 edges after transfer; all outputs are 0 during reset.
2. Rounding/saturation. Widths 8/8/8, OUT_FRAC_SHIFT=4, SAT_EN defined: 64*64 → 127; -3*5 → -1; 24*1 → 2; -128*127 → -128. Same operands with SAT_EN undefined: 64*64 → 0 (256 wraps).
3. Join handshake. Assert data_in_valid alone for 5 cycles → no transfer, state stays IDLE, data_in_ready=0. Then raise weight_valid → transfer on the first cycle both are high.
4. Backpressure. data_out_ready=0 for 10 cycles after valid → data_out and data_out_valid stable, both input readys 0. Release ready with the next vector pending → output consumed and new vector accepted on the same edge; next result arrives NUM_BEATS edges later.
5. Folding sweep. IN_SIZE=8 with PARALLELISM ∈ {1,2,4,8}, random 200-vector streams with random valid/ready → outputs match the golden model. Observed throughput matches NUM_BEATS+1 under full flow.
6. Mid-operation reset. Assert rst_n=0 during COMPUTE beat 1 → data_out_valid=0 and data_out=0 immediately (asynchronous). After release, the next vector produces a correct result with no residue.
